// File: rtl/jtdd_pkg.sv
// Shared types and constants for the JTDD char ROM slot.
// The optional two-entry cache is selected with JTDD_CHAR_CACHE2_EN.
package jtdd_pkg;

  localparam int SDRAM_AW = 22;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  function automatic logic [7:0] sel_byte(input logic [15:0] word, input logic hi);
    sel_byte = hi ? word[15:8] : word[7:0];
  endfunction

endpackage

// File: rtl/jtdd_rom_cache.sv
// Tag/data/valid storage with combinational lookup for the char ROM slot.
// JTDD_CHAR_CACHE2_EN selects two entries with replace-not-most-recently-hit.
module jtdd_rom_cache #(
  parameter int TW = 14
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [TW-1:0] i_tag,
  output logic          o_hit,
  output logic [15:0]   o_data,
  input  logic          i_wr,
  input  logic [TW-1:0] i_wr_tag,
  input  logic [15:0]   i_wr_data
);

`ifdef JTDD_CHAR_CACHE2_EN
  localparam int NE = 2;
`else
  localparam int NE = 1;
`endif

  logic [TW-1:0] r_tag  [NE];
  logic [15:0]   r_data [NE];
  logic [NE-1:0] r_valid;
  logic [NE-1:0] w_hit_oh;
  logic [NE-1:0] w_victim_oh;

  // Lookup of the current tag against all valid entries
  always_comb begin
    o_data   = 16'h0000;
    w_hit_oh = {NE{1'b0}};
    for (int i = 0; i < NE; i++) begin
      if (r_valid[i] && (r_tag[i] == i_tag)) begin
        w_hit_oh[i] = 1'b1;
        o_data      = r_data[i];
      end else begin
        w_hit_oh[i] = 1'b0;
      end
    end
    o_hit = |w_hit_oh;
  end

`ifdef JTDD_CHAR_CACHE2_EN
  logic r_mru;

  // Victim: an empty entry first, otherwise the entry not most recently hit
  always_comb begin
    if (!r_valid[0]) begin
      w_victim_oh = 2'b01;
    end else if (!r_valid[1]) begin
      w_victim_oh = 2'b10;
    end else if (o_hit) begin
      w_victim_oh = ~w_hit_oh;
    end else if (r_mru) begin
      w_victim_oh = 2'b01;
    end else begin
      w_victim_oh = 2'b10;
    end
  end

  // Most-recently-hit tracker
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mru <= 1'b0;
    end else if (o_hit) begin
      r_mru <= w_hit_oh[1];
    end else begin
      r_mru <= r_mru;
    end
  end
`else
  // A single entry is always the victim
  always_comb begin
    w_victim_oh = {NE{1'b1}};
  end
`endif

  // Storage update on a completed fetch
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= {NE{1'b0}};
      for (int i = 0; i < NE; i++) begin
        r_tag[i]  <= {TW{1'b0}};
        r_data[i] <= 16'h0000;
      end
    end else begin
      for (int i = 0; i < NE; i++) begin
        if (i_wr && w_victim_oh[i]) begin
          r_valid[i] <= 1'b1;
          r_tag[i]   <= i_wr_tag;
          r_data[i]  <= i_wr_data;
        end
      end
    end
  end

endmodule

// File: rtl/jtdd_char_rom_slot.sv
// Char ROM slot: serves layer byte reads from a small word cache, filling misses from SDRAM.
// Build option JTDD_CHAR_CACHE2_EN enables a two-entry cache (see jtdd_rom_cache).
module jtdd_char_rom_slot
  import jtdd_pkg::*;
#(
  parameter logic [SDRAM_AW-1:0] OFFSET = 22'h0,
  parameter int                  AW     = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [AW-1:0]       char_addr,
  output logic [7:0]          rom_data,
  output logic                rom_ok,
  output logic [SDRAM_AW-1:0] sdram_addr,
  output logic                sdram_req,
  input  logic                sdram_ack,
  input  logic                data_rdy,
  input  logic [15:0]         sdram_data
);

  localparam int TW = AW - 1;

  state_t              r_state;
  state_t              w_next;
  logic [TW-1:0]       w_cur_tag;
  logic [TW-1:0]       r_tag;
  logic                w_hit;
  logic [15:0]         w_word;
  logic                w_launch;
  logic                w_fill;
  logic [SDRAM_AW-1:0] r_sdram_addr;
  logic                r_sdram_req;
  logic [7:0]          r_rom_data;
  logic                r_rom_ok;

  assign w_cur_tag = char_addr[AW-1:1];

  jtdd_rom_cache #(.TW(TW)) u_cache (
    .clk       (clk),
    .rst       (rst),
    .i_tag     (w_cur_tag),
    .o_hit     (w_hit),
    .o_data    (w_word),
    .i_wr      (w_fill),
    .i_wr_tag  (r_tag),
    .i_wr_data (sdram_data)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state: once launched, a fetch always runs to completion
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (!w_hit)    w_next = ST_REQ;  else w_next = ST_IDLE;
      ST_REQ:  if (sdram_ack) w_next = ST_WAIT; else w_next = ST_REQ;
      ST_WAIT: if (data_rdy)  w_next = ST_IDLE; else w_next = ST_WAIT;
      default: w_next = ST_IDLE;
    endcase
  end

  // FSM decode; handshake strobes only count in their own state
  always_comb begin
    w_launch = (r_state == ST_IDLE) && !w_hit;
    w_fill   = (r_state == ST_WAIT) && data_rdy;
  end

  // Registered outputs and the latched fetch tag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag        <= {TW{1'b0}};
      r_sdram_addr <= {SDRAM_AW{1'b0}};
      r_sdram_req  <= 1'b0;
      r_rom_data   <= 8'h00;
      r_rom_ok     <= 1'b0;
    end else begin
      if (w_launch) begin
        r_tag        <= w_cur_tag;
        r_sdram_addr <= OFFSET + SDRAM_AW'(w_cur_tag);
      end
      r_sdram_req <= (w_next == ST_REQ);
      r_rom_ok    <= w_hit;
      if (w_hit) begin
        r_rom_data <= sel_byte(w_word, char_addr[0]);
      end
    end
  end

  assign sdram_addr = r_sdram_addr;
  assign sdram_req  = r_sdram_req;
  assign rom_data   = r_rom_data;
  assign rom_ok     = r_rom_ok;

endmodule

// File: doc/jtdd_char_rom_slot.md
JTDD_CHAR_ROM_SLOT -- requirements
Module: jtdd_char_rom_slot

Interface
REQ-001 Parameters SHALL be:
- OFFSET, 22'h0, SDRAM word base address of the char ROM region.
- AW, 15, width of the requesting layer's byte address.
REQ-002 Ports SHALL be:
- clk  in  1  system clock; one clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- char_addr  in  AW  byte address from the char layer.
- rom_data  out  8  byte returned to the layer.
- rom_ok  out  1  rom_data is valid for the current char_addr.
- sdram_addr  out  22  word address to the SDRAM controller.
- sdram_req  out  1  fetch request.
- sdram_ack  in  1  controller accepted the request (one-cycle pulse).
- data_rdy  in  1  sdram_data is valid (one-cycle pulse).
- sdram_data  in  16  fetched word.

Function
REQ-003 Word tag SHALL be char_addr[AW-1:1]; byte select SHALL be char_addr[0]: 1 selects sdram_data[15:8], 0 selects [7:0].
REQ-004 Hit SHALL be valid entry with tag equal to current char_addr[AW-1:1]; on hit, rom_data and rom_ok=1 SHALL be registered on the next edge (1-cycle latency).
REQ-005 On miss, rom_ok SHALL be 0 on the next edge and remain 0 until a hit.
REQ-006 FSM states SHALL be IDLE, REQ, WAIT.
- IDLE->REQ on miss: latch tag, drive sdram_addr = OFFSET + tag, assert sdram_req.
- REQ->WAIT on sdram_ack: deassert sdram_req.
- WAIT->IDLE on data_rdy: write word and tag to storage, set valid.
REQ-007 sdram_req SHALL stay high and sdram_addr stable from entry into REQ until sdram_ack.
REQ-008 A char_addr change during REQ or WAIT SHALL NOT abort the fetch; the fetch completes and is stored, then IDLE re-evaluates hit/miss.
REQ-009 Best-case miss latency: sdram_req high on the first edge after the miss; rom_ok high on the second edge after data_rdy.
REQ-010 sdram_ack or data_rdy outside REQ/WAIT respectively SHALL be ignored.
REQ-011 sdram_addr arithmetic SHALL be modulo 2^22; overflow wraps silently.

Reset
REQ-012 On rst: state=IDLE, sdram_req=0, sdram_addr=0, rom_ok=0, rom_data=0, all valid bits cleared.
REQ-013 Reset during REQ or WAIT SHALL drop the request; a data_rdy arriving after reset deassertion SHALL be discarded until a new sdram_ack is received.

Configuration
REQ-014 Macro JTDD_CHAR_CACHE2_EN:
- defined: two entries; miss fill replaces the entry not most recently hit; hit in either entry SHALL give 1-cycle latency.
- undefined: single entry; every tag change not equal to the stored tag is a miss.

Structure
REQ-015 Package jtdd_pkg SHALL hold the FSM state enum and the SDRAM address width constant (22).
REQ-016 Tag/data/valid storage and lookup SHALL be sub-module jtdd_rom_cache (entry count from the macro); FSM and handshake stay in the top.

Verification
REQ-017 Cold miss: after reset, char_addr=15'h0004 -> sdram_req=1, sdram_addr=OFFSET+14'h0002; ack, then data_rdy with 16'hA55A -> rom_data=8'h5A, rom_ok=1.
REQ-018 Same-word byte switch: char_addr 15'h0004->15'h0005 after fill -> no sdram_req, rom_data=8'hA5 one cycle later.
REQ-019 Address change in WAIT: switch 15'h0004->15'h0100 before data_rdy -> first fetch stored, second sdram_req for tag 14'h0080 follows, rom_ok=0 meanwhile.
REQ-020 Reset in WAIT: rst pulse, then stray data_rdy -> storage unchanged, rom_ok=0, new request issued for current address.
REQ-021 With JTDD_CHAR_CACHE2_EN: alternate tags 14'h0010/14'h0020 after both filled -> zero further sdram_req; third tag 14'h0030 evicts least recently hit.
REQ-022 Wrap: OFFSET=22'h3FFFFF, tag 14'h0002 -> sdram_addr=22'h000001.
